// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU execute unit:
//   - alu_op_e : 4-bit internal operation encodings
//   - ALUOP_*  : 2-bit ALUop control constants from the main decoder
//   - F7_*     : funct7 groups recognised by the R-type decoder
//   - state_e  : execute-unit FSM states
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0110,
        OP_SLL  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1001,
        OP_XOR  = 4'b1010,
        OP_SLTU = 4'b1011,
        OP_MUL  = 4'b1100,
        OP_SLT  = 4'b1111
    } alu_op_e;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
// Combinational translation of ALUop/funct7/funct3 into an internal op code.
// Ports:
//   alu_op  (in, 2)  : 00 ADD, 01 SUB, 10 R-type decode, 11 illegal
//   funct7  (in, 7)  : R-type qualifier
//   funct3  (in, 3)  : R-type qualifier
//   op      (out, 4) : decoded operation (only meaningful when illegal=0)
//   illegal (out, 1) : combination not supported by this unit
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int MUL_EN = 1
) (
    input  logic [1:0] alu_op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output alu_op_e    op,
    output logic       illegal
);

    always_comb begin
        op      = OP_ADD;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  op = OP_ADD;
                            3'b001:  op = OP_SLL;
                            3'b010:  op = OP_SLT;
                            3'b011:  op = OP_SLTU;
                            3'b100:  op = OP_XOR;
                            3'b101:  op = OP_SRL;
                            3'b110:  op = OP_OR;
                            default: op = OP_AND;
                        endcase
                    end
                    F7_ALT: begin
                        case (funct3)
                            3'b000:  op = OP_SUB;
                            3'b101:  op = OP_SRA;
                            default: illegal = 1'b1;
                        endcase
                    end
                    F7_MULDIV: begin
                        // With the multiplier compiled out, MUL decodes as illegal.
                        if (funct3 == 3'b000 && MUL_EN != 0) begin
                            op = OP_MUL;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Single-issue ALU execute stage with valid/ready handshakes on both sides.
// Single-cycle ops complete with latency 1; MUL runs an XLEN-step shift-add
// loop. The result is held in HOLD until the consumer takes it.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush                   : drop the in-flight op and any pending result
//   in_valid / in_ready     : request handshake
//   ALUop, funct7, funct3   : operation select
//   op_a, op_b   (XLEN)     : operands
//   out_valid / out_ready   : result handshake
//   result       (XLEN)     : registered result
//   zero                    : result == 0
//   illegal                 : registered "request was undecodable" flag
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUop,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    alu_op_e                dec_op;
    logic                   dec_illegal;
    state_e                 state;
    logic                   accept;
    logic [SHW-1:0]         shamt;
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [XLEN-1:0]        alu_res;

    // Shift-add multiplier state
    logic [XLEN-1:0]        mcand;
    logic [XLEN-1:0]        mplier;
    logic [XLEN-1:0]        acc;
    logic [XLEN-1:0]        acc_next;
    logic [SHW-1:0]         mul_cnt;

    alu_op_decode #(
        .MUL_EN (MUL_EN)
    ) u_decode (
        .alu_op  (ALUop),
        .funct7  (funct7),
        .funct3  (funct3),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    // flush wins over everything, so it also blocks acceptance.
    assign in_ready = !flush &&
                      ((state == ST_IDLE && !out_valid) ||
                       (state == ST_HOLD && out_ready));
    assign accept   = in_valid && in_ready;
    assign shamt    = op_b[SHW-1:0];
    assign a_s      = $signed(op_a);
    assign b_s      = $signed(op_b);
    assign zero     = (result == '0);
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = a_s >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            default: alu_res = '0;   // MUL is produced by the iterative path
        endcase
        if (dec_illegal) begin
            alu_res = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            mul_cnt   <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    // Completion first; a same-cycle accept below overrides it.
                    if (state == ST_HOLD && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (dec_op == OP_MUL && !dec_illegal) begin
                            state     <= ST_MUL;
                            out_valid <= 1'b0;
                            mcand     <= op_a;
                            mplier    <= op_b;
                            acc       <= '0;
                            mul_cnt   <= '0;
                        end else begin
                            state     <= ST_HOLD;
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            illegal   <= dec_illegal;
                        end
                    end
                end
                ST_MUL: begin
                    acc     <= acc_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt + 1'b1;
                    // Last of XLEN iterations: publish the final partial sum.
                    if (mul_cnt == SHW'(XLEN - 1)) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        result    <= acc_next;
                        illegal   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (power of two, 8..64).
REQ-002 SHALL have parameter MUL_EN, default 1; 1 enables the iterative MUL, 0 makes MUL illegal.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  discard in-flight op and pending result.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  unit accepts request this cycle.
REQ-008 SHALL have port ALUop  input  2  00 ADD (lw/sw), 01 SUB (beq), 10 R-type decode, 11 illegal.
REQ-009 SHALL have ports funct7 (input, 7 bits) and funct3 (input, 3 bits), R-type qualifiers.
REQ-010 SHALL have ports op_a and op_b, each input, XLEN bits, operands.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port result  output  XLEN  registered result.
REQ-014 SHALL have port zero (output, 1 bit, result==0) and port illegal (output, 1 bit, undecodable request).

Function
REQ-015 R-type decode SHALL be: f7=0000000 with f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND; f7=0100000 with f3 000 SUB, 101 SRA; f7=0000001 with f3 000 MUL.
REQ-016 Every other ALUop/funct7/funct3 combination SHALL complete in 1 cycle with result=0, illegal=1.
REQ-017 Shift amount SHALL be op_b[$clog2(XLEN)-1:0]; SRA sign-extends; SLT signed, SLTU unsigned; result 1 or 0.
REQ-018 ADD/SUB/MUL SHALL wrap modulo 2^XLEN; MUL returns low XLEN bits of the product.
REQ-019 FSM SHALL have states IDLE, MUL, HOLD.
REQ-020 A request is accepted when in_valid and in_ready are both high.
REQ-021 in_ready SHALL be high only in IDLE with out_valid low, or in HOLD with out_ready high.
REQ-022 A non-MUL accept SHALL load result and illegal, go to HOLD, and assert out_valid next cycle (latency 1).
REQ-023 A MUL accept SHALL go to MUL for exactly XLEN shift-add iterations, one per cycle, then to HOLD; out_valid rises XLEN+1 cycles after accept.
REQ-024 In HOLD, result, zero and illegal SHALL stay stable until out_ready is high.
REQ-025 On handshake completion in HOLD without a new accept, state SHALL return to IDLE; with a simultaneous accept, state SHALL load the new op (back-to-back, no bubble).
REQ-026 flush SHALL take priority over accept and completion: next state IDLE, out_valid 0, the accept that cycle is ignored, and in_ready SHALL be forced low that cycle.
REQ-027 zero SHALL be combinational from the registered result.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, out_valid=0, result=0, illegal=0, and clear the multiplier registers.
REQ-029 Reset mid-MUL SHALL abandon the op; in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-030 A shared package alu_pkg SHALL hold the 4-bit op encodings (AND 0000, OR 0001, ADD 0010, SUB 0110, SLL 0111, SRL 1000, SRA 1001, XOR 1010, SLTU 1011, MUL 1100, SLT 1111), the ALUop constants and the FSM state typedef.
REQ-031 Decode SHALL be a combinational sub-module alu_op_decode (ALUop, funct7, funct3, MUL_EN -> op, illegal), instantiated once.

Verification (XLEN=32)
REQ-032 ALUop=10, f7=0100000, f3=000, a=5, b=7 -> next cycle out_valid=1, result=0xFFFFFFFE, zero=0.
REQ-033 SRA a=0x80000000, b=0x24 (shamt 4) -> result=0xF8000000; SRL same inputs -> 0x08000000.
REQ-034 MUL a=0x00012345, b=0x100 -> in_ready=0 for 32 cycles, out_valid on cycle 33, result=0x01234500.
REQ-035 out_ready=0 for 5 cycles after SUB a=b=9 -> result=0, zero=1 held stable, in_ready=0; then out_ready=1 with a new in_valid accepted in the same cycle.
REQ-036 flush at MUL cycle 10 -> out_valid never asserts, in_ready=1 next cycle; f7=0000010 -> illegal=1, result=0.
REQ-037 rst_n low mid-MUL -> out_valid=0 immediately; after release an ADD 3+4 -> result=7.
